// File: rtl/bus_oe_sequencer.sv
// -----------------------------------------------------------------------------
// bus_oe_sequencer
//
// Hands a shared bus between N_SRC sources by generating registered, one-hot
// (or all-zero) output enables. When ownership moves from one source to
// another, or the bus is released, GAP dead cycles with every enable low are
// inserted, so two drivers are never enabled in the same cycle.
//
// Ports
//   clk     : sole clock, rising edge
//   reset   : synchronous, active-high reset
//   req     : request strobe, sampled every cycle
//   reqSel  : requested source index
//   reqEn   : 1 = drive reqSel, 0 = release the bus
//   ready   : request is accepted this cycle if req=1 (low during turnaround)
//   oe      : registered output enables, one-hot or all-zero
//   curSel  : index of the current or last driver
//   driving : high iff oe is non-zero, registered together with oe
//   err     : one-cycle pulse after an out-of-range request is rejected
// -----------------------------------------------------------------------------
module bus_oe_sequencer #(
  parameter int N_SRC = 16,
  parameter int SEL_W = $clog2(N_SRC),
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [SEL_W-1:0] reqSel,
  input  logic             reqEn,
  output logic             ready,
  output logic [N_SRC-1:0] oe,
  output logic [SEL_W-1:0] curSel,
  output logic             driving,
  output logic             err
);

  // With GAP=0 the counter is never used; keep it one bit wide so it exists.
  localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic [N_SRC-1:0] r_oe,         w_oe_nxt;
  logic [SEL_W-1:0] r_cur_sel,    w_cur_sel_nxt;
  logic [SEL_W-1:0] r_pend_sel,   w_pend_sel_nxt;
  // 1: the turnaround ends in DRIVE on r_pend_sel; 0: it ends in IDLE.
  logic             r_pend_drive, w_pend_drive_nxt;
  logic [CNT_W-1:0] r_gap_cnt,    w_gap_cnt_nxt;
  logic             r_err,        w_err_nxt;
  logic             r_driving;

  logic             w_ready;
  logic             w_accept;
  logic             w_sel_ok;

  function automatic logic [N_SRC-1:0] f_onehot(input logic [SEL_W-1:0] sel);
    return {{(N_SRC-1){1'b0}}, 1'b1} << sel;
  endfunction

  assign w_ready  = (r_state != ST_TURN);
  // A request seen during turnaround is dropped, not queued.
  assign w_accept = req && w_ready;
  // One extra bit so N_SRC itself is representable when N_SRC is a power of 2.
  assign w_sel_ok = ({1'b0, reqSel} < (SEL_W + 1)'(N_SRC));

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through this block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt      = r_state;
    w_oe_nxt         = r_oe;
    w_cur_sel_nxt    = r_cur_sel;
    w_pend_sel_nxt   = r_pend_sel;
    w_pend_drive_nxt = r_pend_drive;
    w_gap_cnt_nxt    = r_gap_cnt;
    w_err_nxt        = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_sel_ok) begin
            w_err_nxt = 1'b1;
          end else if (reqEn) begin
            w_state_nxt   = ST_DRIVE;
            w_oe_nxt      = f_onehot(reqSel);
            w_cur_sel_nxt = reqSel;
          end
        end
      end

      ST_DRIVE: begin
        if (w_accept) begin
          if (!w_sel_ok) begin
            w_err_nxt = 1'b1;
          end else if (reqEn) begin
            // Re-requesting the current owner keeps the bus with no gap.
            if (reqSel != r_cur_sel) begin
              if (GAP == 0) begin
                w_oe_nxt      = f_onehot(reqSel);
                w_cur_sel_nxt = reqSel;
              end else begin
                w_state_nxt      = ST_TURN;
                w_oe_nxt         = '0;
                w_pend_sel_nxt   = reqSel;
                w_pend_drive_nxt = 1'b1;
                w_gap_cnt_nxt    = GAP_LOAD;
              end
            end
          end else begin
            // Release: curSel keeps the last owner.
            w_oe_nxt = '0;
            if (GAP == 0) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_state_nxt      = ST_TURN;
              w_pend_drive_nxt = 1'b0;
              w_gap_cnt_nxt    = GAP_LOAD;
            end
          end
        end
      end

      ST_TURN: begin
        // Counter loaded with GAP-1 gives exactly GAP cycles in TURN.
        if (r_gap_cnt == '0) begin
          if (r_pend_drive) begin
            w_state_nxt   = ST_DRIVE;
            w_oe_nxt      = f_onehot(r_pend_sel);
            w_cur_sel_nxt = r_pend_sel;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_oe_nxt    = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_oe         <= '0;
      r_cur_sel    <= '0;
      r_pend_sel   <= '0;
      r_pend_drive <= 1'b0;
      r_gap_cnt    <= '0;
      r_err        <= 1'b0;
      r_driving    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_oe         <= w_oe_nxt;
      r_cur_sel    <= w_cur_sel_nxt;
      r_pend_sel   <= w_pend_sel_nxt;
      r_pend_drive <= w_pend_drive_nxt;
      r_gap_cnt    <= w_gap_cnt_nxt;
      r_err        <= w_err_nxt;
      r_driving    <= |w_oe_nxt;
    end
  end

  assign ready   = w_ready;
  assign oe      = r_oe;
  assign curSel  = r_cur_sel;
  assign driving = r_driving;
  assign err     = r_err;

endmodule

// File: tb/tb_bus_oe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_oe_sequencer
//
// Three instances share clock and reset:
//   id 0 : N_SRC=16, GAP=1
//   id 1 : N_SRC=16, GAP=3
//   id 2 : N_SRC=12, GAP=1
// Each directed step drives one instance, pushes the expected post-edge
// outputs onto a scoreboard queue, and pops/compares them #1 after the edge.
// -----------------------------------------------------------------------------
module tb_bus_oe_sequencer;

  typedef struct {
    int          id;
    string       tag;
    logic [15:0] oe;
    logic [3:0]  cur;
    logic        rdy;
    logic        drv;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic        req_a [3];
  logic [3:0]  sel_a [3];
  logic        en_a  [3];
  logic        rdy_a [3];
  logic [15:0] oe_a  [3];
  logic [3:0]  cur_a [3];
  logic        drv_a [3];
  logic        err_a [3];
  logic [11:0] oe12;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  bus_oe_sequencer #(.N_SRC(16), .GAP(1)) dut_g1 (
    .clk(clk), .reset(rst), .req(req_a[0]), .reqSel(sel_a[0]), .reqEn(en_a[0]),
    .ready(rdy_a[0]), .oe(oe_a[0]), .curSel(cur_a[0]), .driving(drv_a[0]),
    .err(err_a[0])
  );

  bus_oe_sequencer #(.N_SRC(16), .GAP(3)) dut_g3 (
    .clk(clk), .reset(rst), .req(req_a[1]), .reqSel(sel_a[1]), .reqEn(en_a[1]),
    .ready(rdy_a[1]), .oe(oe_a[1]), .curSel(cur_a[1]), .driving(drv_a[1]),
    .err(err_a[1])
  );

  bus_oe_sequencer #(.N_SRC(12), .GAP(1)) dut_n12 (
    .clk(clk), .reset(rst), .req(req_a[2]), .reqSel(sel_a[2]), .reqEn(en_a[2]),
    .ready(rdy_a[2]), .oe(oe12), .curSel(cur_a[2]), .driving(drv_a[2]),
    .err(err_a[2])
  );

  assign oe_a[2] = {4'h0, oe12};

  task automatic check(input string tag, input string fld,
                       input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
  endtask

  // One clock: drive instance id (others idle), predict, sample, compare.
  task automatic step(input int id, input string tag, input logic r,
                      input logic rq, input logic [3:0] sel, input logic en,
                      input logic [15:0] e_oe, input logic [3:0] e_cur,
                      input logic e_rdy, input logic e_drv, input logic e_err);
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 1'b0;
      sel_a[k] = 4'h0;
      en_a[k]  = 1'b0;
    end
    rst       = r;
    req_a[id] = rq;
    sel_a[id] = sel;
    en_a[id]  = en;
    e = '{id: id, tag: tag, oe: e_oe, cur: e_cur, rdy: e_rdy, drv: e_drv,
          err: e_err};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, "oe",      oe_a[e.id],           e.oe);
    check(e.tag, "curSel",  {12'h0, cur_a[e.id]}, {12'h0, e.cur});
    check(e.tag, "ready",   {15'h0, rdy_a[e.id]}, {15'h0, e.rdy});
    check(e.tag, "driving", {15'h0, drv_a[e.id]}, {15'h0, e.drv});
    check(e.tag, "err",     {15'h0, err_a[e.id]}, {15'h0, e.err});
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_a[k] = 1'b0;
      sel_a[k] = 4'h0;
      en_a[k]  = 1'b0;
    end

    // Reset state of every instance, including the first cycle after reset.
    step(0, "rst_g1",  1, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);
    step(1, "rst_g3",  1, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);
    step(2, "rst_n12", 1, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);
    step(0, "post_rst", 0, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);

    // GAP=3: switch 3 -> 5 gives three dead cycles, then 5.
    step(1, "g3_drv3",  0, 1, 4'd3, 1, 16'h0008, 4'd3, 1, 1, 0);
    step(1, "g3_sw_c1", 0, 1, 4'd5, 1, 16'h0000, 4'd3, 0, 0, 0);
    step(1, "g3_sw_c2", 0, 0, 4'd0, 0, 16'h0000, 4'd3, 0, 0, 0);
    step(1, "g3_sw_c3", 0, 1, 4'd9, 1, 16'h0000, 4'd3, 0, 0, 0);
    step(1, "g3_sw_c4", 0, 0, 4'd0, 0, 16'h0020, 4'd5, 1, 1, 0);
    // GAP=3 release: three turnaround cycles, then IDLE with curSel kept.
    step(1, "g3_rel_c1", 0, 1, 4'd5, 0, 16'h0000, 4'd5, 0, 0, 0);
    step(1, "g3_rel_c2", 0, 0, 4'd0, 0, 16'h0000, 4'd5, 0, 0, 0);
    step(1, "g3_rel_c3", 0, 0, 4'd0, 0, 16'h0000, 4'd5, 0, 0, 0);
    step(1, "g3_rel_c4", 0, 0, 4'd0, 0, 16'h0000, 4'd5, 1, 0, 0);

    // N_SRC=12: out-of-range request rejected with a one-cycle err pulse.
    step(2, "n12_drv2",  0, 1, 4'd2,  1, 16'h0004, 4'd2,  1, 1, 0);
    step(2, "n12_bad13", 0, 1, 4'd13, 1, 16'h0004, 4'd2,  1, 1, 1);
    step(2, "n12_after", 0, 0, 4'd0,  0, 16'h0004, 4'd2,  1, 1, 0);
    step(2, "n12_bad12", 0, 1, 4'd12, 1, 16'h0004, 4'd2,  1, 1, 1);
    step(2, "n12_sw11",  0, 1, 4'd11, 1, 16'h0000, 4'd2,  0, 0, 0);
    step(2, "n12_drv11", 0, 0, 4'd0,  0, 16'h0800, 4'd11, 1, 1, 0);

    // GAP=1: drive 3, switch to 5 (request during TURN ignored).
    step(0, "g1_drv3",   0, 1, 4'd3, 1, 16'h0008, 4'd3, 1, 1, 0);
    step(0, "g1_sw_c1",  0, 1, 4'd5, 1, 16'h0000, 4'd3, 0, 0, 0);
    step(0, "g1_sw_c2",  0, 1, 4'd9, 1, 16'h0020, 4'd5, 1, 1, 0);
    // Same owner re-requested: no gap, oe steady.
    for (int i = 0; i < 4; i++)
      step(0, "g1_same5", 0, 1, 4'd5, 1, 16'h0020, 4'd5, 1, 1, 0);
    // Release: one dead cycle (request there ignored), then IDLE.
    step(0, "g1_rel_c1", 0, 1, 4'd5, 0, 16'h0000, 4'd5, 0, 0, 0);
    step(0, "g1_rel_c2", 0, 1, 4'd2, 1, 16'h0000, 4'd5, 1, 0, 0);
    // Release request in IDLE is a no-op.
    step(0, "g1_idle_rel", 0, 1, 4'd0, 0, 16'h0000, 4'd5, 1, 0, 0);
    // Reset during TURN with 7 pending: 7 must never be enabled.
    step(0, "g1_drv5",   0, 1, 4'd5, 1, 16'h0020, 4'd5, 1, 1, 0);
    step(0, "g1_turn7",  0, 1, 4'd7, 1, 16'h0000, 4'd5, 0, 0, 0);
    step(0, "g1_rst_tn", 1, 1, 4'd7, 1, 16'h0000, 4'd0, 1, 0, 0);
    step(0, "g1_no7_a",  0, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);
    step(0, "g1_no7_b",  0, 0, 4'd0, 0, 16'h0000, 4'd0, 1, 0, 0);
    // Reset during DRIVE overrides a simultaneous request.
    step(0, "g1_drv4",   0, 1, 4'd4, 1, 16'h0010, 4'd4, 1, 1, 0);
    step(0, "g1_rst_dr", 1, 1, 4'd6, 1, 16'h0000, 4'd0, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_oe_sequencer.md
BUS_OE_SEQUENCER -- requirements
Module: bus_oe_sequencer

Interface
Parameters (name, default, meaning):
- REQ-001: The block SHALL have parameter N_SRC, default 16: number of bus sources; legal range 2..64.
- REQ-002: The block SHALL have parameter SEL_W, default $clog2(N_SRC): select field width.
- REQ-003: The block SHALL have parameter GAP, default 1: dead cycles inserted between drivers; legal range 0..15.

Ports (name, direction, width, meaning):
- REQ-004: clk, input, 1: sole clock; all state updates on the rising edge.
- REQ-005: reset, input, 1: synchronous, active-high reset.
- REQ-006: req, input, 1: request strobe, sampled each cycle.
- REQ-007: reqSel, input, SEL_W: requested source index.
- REQ-008: reqEn, input, 1: 1 = drive reqSel; 0 = release the bus.
- REQ-009: ready, output, 1: request accepted this cycle if req=1.
- REQ-010: oe, output, N_SRC: registered output enables, one-hot or all-zero.
- REQ-011: curSel, output, SEL_W: index of the current or last driver.
- REQ-012: driving, output, 1: high iff oe is non-zero.
- REQ-013: err, output, 1: one-cycle pulse on a rejected out-of-range request.

Function
- REQ-014: The block SHALL implement states IDLE (oe=0), DRIVE (oe=1<<curSel) and TURN (oe=0, gap counter active).
- REQ-015: ready SHALL be 1 in IDLE and DRIVE and 0 in TURN.
- REQ-016: A request SHALL be accepted only when req=1 and ready=1; req while ready=0 SHALL have no effect and SHALL NOT be queued.
- REQ-017: An accepted request with reqSel >= N_SRC SHALL be rejected: err=1 for the next cycle, and state, oe and curSel unchanged.
- REQ-018: IDLE + accepted (reqEn=1, sel legal) SHALL enter DRIVE with oe=1<<reqSel and curSel=reqSel on the next edge (latency 1).
- REQ-019: DRIVE + accepted (reqEn=1, reqSel==curSel) SHALL leave state and oe unchanged, with no gap.
- REQ-020: DRIVE + accepted (reqEn=1, legal reqSel!=curSel) SHALL behave as follows:
  - GAP>0: next edge oe=0 and state TURN; reqSel held as pending.
  - After exactly GAP cycles of oe=0, enter DRIVE with oe=1<<pending and curSel=pending.
  - GAP=0: switch directly to the new one-hot in one edge.
  - Two bits of oe SHALL never be high in the same cycle.
- REQ-021: DRIVE + accepted (reqEn=0) SHALL set oe=0 on the next edge, then:
  - GAP>0: TURN for GAP cycles, then IDLE.
  - GAP=0: IDLE directly.
  - curSel retains its last value.
- REQ-022: IDLE + accepted (reqEn=0) SHALL be a no-op.
- REQ-023: The gap counter SHALL be $clog2(GAP+1) bits wide, load GAP-1 on TURN entry, decrement each cycle, and exit TURN at zero; it SHALL NOT wrap.
- REQ-024: driving SHALL equal |oe, registered together with oe.

Reset
- REQ-025: While reset=1 at an edge, the block SHALL set state=IDLE, oe=0, curSel=0, err=0, driving=0 and gap counter=0, discarding any pending select.
- REQ-026: ready SHALL be 1 in the first cycle after reset deasserts.
- REQ-027: Reset SHALL take priority over any simultaneous req, including reset during TURN or DRIVE.

Verification (N_SRC=16, GAP=1 unless stated)
- REQ-028: Post-reset, req=1, reqSel=3, reqEn=1 at cycle 0 -> cycle 1: oe=16'h0008, driving=1, curSel=3, ready=1.
- REQ-029: Driving 3, req reqSel=5 at cycle 0 -> cycle 1: oe=0, ready=0; cycle 2: oe=16'h0020, curSel=5, ready=1. With GAP=3, oe=0 for cycles 1-3 and 16'h0020 at cycle 4.
- REQ-030: Driving 5, req reqSel=5 every cycle for 4 cycles -> oe stays 16'h0020 throughout, ready stays 1.
- REQ-031: N_SRC=12, driving 2, req reqSel=13 -> next cycle err=1, oe=12'h004; the following cycle err=0.
- REQ-032: Driving 5, req reqEn=0 -> cycle 1: oe=0, ready=0; cycle 2: IDLE, ready=1, curSel=5. A req at cycle 1 is ignored.
- REQ-033: Reset asserted during TURN (pending 7) -> next cycle oe=0, curSel=0, ready=1; 16'h0080 never appears.
